l0_row_feeder: RTL and testbench
================================

Name: l0_row_feeder

Overview:
Upstream feeder on the west edge of the mac_tile systolic array. It buffers one bw-bit value per array row in a per-row FIFO. It issues those values, together with a 2-bit instruction, onto each row's in_w/inst_w. Row r is skewed by r cycles so operands meet the diagonal wavefront. The same block carries weights during load (inst 01) and activations during execute (inst 10).

Parameters:
row, 8, number of array rows (per-row FIFOs)
bw, 4, data width per row; matches mac_tile bw
depth, 64, entries per row FIFO; power of two
cnt_bw, 7, occupancy counter width, log2(depth)+1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
wr  input  1  write request; pushes in into all row FIFOs
in  input  row*bw  write vector; row r at bits [r*bw +: bw]
full  output  1  any row FIFO holds depth entries
rd  input  1  read/issue request
inst_in  input  2  instruction issued with the read: 01 load weight, 10 execute, 00 flush-pop
empty  output  1  row 0 FIFO holds no entries
count  output  cnt_bw  row 0 occupancy
out  output  row*bw  per-row data to mac_tile in_w; row r at [r*bw +: bw]
inst_out  output  row*2  per-row instruction to mac_tile inst_w; row r at [2r +: 2]

Behaviour:
- Reset (async, active-high):
  - all read/write pointers 0; token shift register cleared
  - out=0, inst_out=0, full=0, empty=1, count=0
  - reset mid-drain discards in-flight tokens and FIFO contents; no pop completes after reset asserts
- Storage:
  - each row FIFO is depth x bw, with pointers of log2(depth)+1 bits (extra wrap bit)
  - full/empty are derived from pointer equality plus the wrap bit
  - pointers wrap modulo depth with no bubble
- Write:
  - accepted iff wr && !full; writes in[r] into FIFO r for every r in the same cycle
  - wr while full is dropped silently; no pointer moves
- Read issue:
  - accepted iff rd && !empty (row 0 state); sets token[0] and latches inst_in into the token
  - rd while empty is ignored: no token, nothing changes
- Skew pipeline:
  - token and inst shift one row per cycle: token[r] at cycle t becomes token[r+1] at t+1
  - row r pops its FIFO in the cycle its token is present
  - registered result: out[r] <= popped data, inst_out[r] <= token inst
- Latency:
  - rd accepted at edge t → row 0 out/inst_out valid after edge t+1
  - row r valid after edge t+1+r
- Back-to-back rd issues one token per cycle; throughput is 1 vector/cycle.
- Idle rows:
  - rows with no token that cycle drive inst_out[r]=00
  - out[r] holds its last value (mac_tile ignores data when inst is 00)
- Lag and occupancy:
  - row r lags row 0 by up to r pops, so row row-1 has the highest occupancy
  - full is the OR over all rows; count and empty reflect row 0 only
- Simultaneous events:
  - wr && rd when neither full nor empty: both occur; row 0 count unchanged
  - wr && rd when full: pop/issue proceeds, write dropped (full evaluated on pre-edge state)
  - wr && rd when empty: write accepted, rd ignored; empty deasserts next cycle
- Instruction values:
  - inst_in=00 with rd pops and emits 00 (flush/discard)
  - inst_in=11 is forwarded unchanged; it is the caller's error
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, then write 3 vectors (row r = r+1, r+2, r+3), then rd with inst_in=01 for 3 cycles → row 0 emits 1,2,3 with inst 01 starting 1 cycle after the first rd. Row 7 emits 8,9,10 starting 8 cycles after it. Idle rows show inst 00.
2. Write 64 vectors with no reads → full=1 and count=64 after the 64th. A 65th write (value 0xF) is dropped, and a later drain shows no 0xF.
3. With empty=1, assert rd with inst_in=10 for 5 cycles → inst_out stays all 00, pointers unchanged, empty=1.
4. Stream 200 writes and 200 reads concurrently (values 0..199 mod 16) with inst 10 → every row outputs the exact sequence in order across pointer wrap. count never exceeds 64, and no entry is lost or duplicated.
5. Full FIFO plus simultaneous wr && rd → pop occurs, write dropped, count goes 64→63.
6. Assert reset 3 cycles into a 10-vector drain → all inst_out=00 immediately, empty=1, count=0. Rows with pending tokens emit nothing after reset deasserts.

Source files
------------

// File: rtl/l0_row_feeder.sv
// West-edge row feeder for the mac_tile array: per-row FIFOs drained by a
// diagonal token wave so row r issues its operand r cycles after row 0.
module l0_row_feeder #(
  parameter int unsigned row    = 8,
  parameter int unsigned bw     = 4,
  parameter int unsigned depth  = 64,
  parameter int unsigned cnt_bw = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in,
  output logic                full,
  input  logic                rd,
  input  logic [1:0]          inst_in,
  output logic                empty,
  output logic [cnt_bw-1:0]   count,
  output logic [row*bw-1:0]   out,
  output logic [row*2-1:0]    inst_out
);

  localparam int unsigned addr_w = $clog2(depth);
  localparam int unsigned ptr_w  = addr_w + 1;

  logic [bw-1:0]    mem [row][depth];
  logic [ptr_w-1:0] wr_ptr, wr_ptr_nxt;
  // Row 0 issue pointer runs ahead of its pop pointer by the token in flight,
  // so back-to-back reads never issue more tokens than stored entries.
  logic [ptr_w-1:0] iss_ptr, iss_ptr_nxt;
  logic [ptr_w-1:0] rd_ptr     [row];
  logic [ptr_w-1:0] rd_ptr_nxt [row];
  logic [row-1:0]   tok;
  logic [1:0]       tok_inst [row];
  logic             wr_acc, rd_acc;
  logic             full_nxt, empty_nxt;
  logic [cnt_bw-1:0] count_nxt;

  // Accept decisions, next pointers and next flag values
  always_comb begin
    wr_acc      = wr && !full;
    rd_acc      = rd && !empty;
    wr_ptr_nxt  = wr_ptr + ptr_w'(wr_acc);
    iss_ptr_nxt = iss_ptr + ptr_w'(rd_acc);
    full_nxt    = 1'b0;
    for (int r = 0; r < int'(row); r++) begin
      rd_ptr_nxt[r] = rd_ptr[r] + ptr_w'(tok[r]);
      if ((wr_ptr_nxt[addr_w-1:0] == rd_ptr_nxt[r][addr_w-1:0]) &&
          (wr_ptr_nxt[addr_w] != rd_ptr_nxt[r][addr_w]))
        full_nxt = 1'b1;
    end
    empty_nxt = (wr_ptr_nxt == iss_ptr_nxt);
    count_nxt = cnt_bw'(wr_ptr_nxt - iss_ptr_nxt);
  end

  // Storage array; contents are don't-care after reset since pointers clear
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int r = 0; r < int'(row); r++)
        mem[r][wr_ptr[addr_w-1:0]] <= in[r*bw +: bw];
    end
  end

  // Pointers, token wave and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      iss_ptr  <= '0;
      tok      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      count    <= '0;
      out      <= '0;
      inst_out <= '0;
      for (int r = 0; r < int'(row); r++) begin
        rd_ptr[r]   <= '0;
        tok_inst[r] <= 2'b00;
      end
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      iss_ptr     <= iss_ptr_nxt;
      full        <= full_nxt;
      empty       <= empty_nxt;
      count       <= count_nxt;
      tok         <= {tok[row-2:0], rd_acc};
      tok_inst[0] <= rd_acc ? inst_in : 2'b00;
      for (int r = 1; r < int'(row); r++)
        tok_inst[r] <= tok_inst[r-1];
      for (int r = 0; r < int'(row); r++) begin
        rd_ptr[r] <= rd_ptr_nxt[r];
        if (tok[r])
          out[r*bw +: bw] <= mem[r][rd_ptr[r][addr_w-1:0]];
        inst_out[r*2 +: 2] <= tok[r] ? tok_inst[r] : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_l0_row_feeder.sv
// Directed self-checking bench for l0_row_feeder: skew, full/empty boundaries,
// wrap-around streaming, instruction forwarding and mid-drain reset.
module tb_l0_row_feeder;

  localparam int unsigned n_row  = 8;
  localparam int unsigned bw     = 4;
  localparam int unsigned depth  = 64;
  localparam int unsigned cnt_bw = 7;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr;
  logic [n_row*bw-1:0]    in;
  logic                   full;
  logic                   rd;
  logic [1:0]             inst_in;
  logic                   empty;
  logic [cnt_bw-1:0]      count;
  logic [n_row*bw-1:0]    out;
  logic [n_row*2-1:0]     inst_out;

  int checks   = 0;
  int failures = 0;
  int idx [n_row];

  l0_row_feeder #(.row(n_row), .bw(bw), .depth(depth), .cnt_bw(cnt_bw)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .full(full), .rd(rd),
    .inst_in(inst_in), .empty(empty), .count(count), .out(out), .inst_out(inst_out)
  );

  always #5 clk = ~clk;

  function automatic logic [n_row*bw-1:0] mk_vec(input int base, input int rstep, input int modv);
    logic [n_row*bw-1:0] v;
    v = '0;
    for (int r = 0; r < int'(n_row); r++) v[r*bw +: bw] = bw'((base + r*rstep) % modv);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; inst_in = 2'b00; in = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic clear_idx;
    for (int r = 0; r < int'(n_row); r++) idx[r] = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || count !== 7'd0 || out !== '0 || inst_out !== '0) begin
      failures++;
      $display("FAIL reset_state: full=%b empty=%b count=%0d out=%h inst=%h, want 0 1 0 0 0",
               full, empty, count, out, inst_out);
    end
  endtask

  task automatic test_skew;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1; in = mk_vec(k + 1, 1, 16); tick;
    end
    wr = 1'b0;
    checks++;
    if (count !== 7'd3 || empty !== 1'b0) begin
      failures++;
      $display("FAIL skew_fill: count=%0d empty=%b, want 3 0", count, empty);
    end
    for (int c = 0; c <= 12; c++) begin
      rd = (c < 3); inst_in = 2'b01; tick;
      if (c == 0) begin
        checks++;
        if (count !== 7'd2) begin
          failures++;
          $display("FAIL skew_issue_count: count=%0d, want 2", count);
        end
      end
      for (int r = 0; r < int'(n_row); r++) begin
        int k;
        logic [1:0] exp_inst;
        k = c - 1 - r;
        exp_inst = (k >= 0 && k < 3) ? 2'b01 : 2'b00;
        checks++;
        if (inst_out[2*r +: 2] !== exp_inst) begin
          failures++;
          $display("FAIL skew_inst c=%0d row=%0d: got %b want %b", c, r, inst_out[2*r +: 2], exp_inst);
        end
        if (exp_inst != 2'b00) begin
          checks++;
          if (out[r*bw +: bw] !== bw'(c)) begin
            failures++;
            $display("FAIL skew_data c=%0d row=%0d: got %h want %h", c, r, out[r*bw +: bw], bw'(c));
          end
        end
      end
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 7'd0) begin
      failures++;
      $display("FAIL skew_end: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < int'(depth); i++) begin
      wr = 1'b1; in = mk_vec(i, 0, 15); tick;
      if (i == int'(depth) - 2) begin
        checks++;
        if (full !== 1'b0 || count !== 7'd63) begin
          failures++;
          $display("FAIL full_63: full=%b count=%0d, want 0 63", full, count);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 7'd64) begin
      failures++;
      $display("FAIL full_64: full=%b count=%0d, want 1 64", full, count);
    end
    in = mk_vec(15, 0, 16); tick;
    wr = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 7'd64) begin
      failures++;
      $display("FAIL full_drop: full=%b count=%0d, want 1 64", full, count);
    end
    clear_idx;
    for (int c = 0; c < int'(depth + n_row) + 2; c++) begin
      rd = (c < int'(depth)); inst_in = 2'b10; tick;
      for (int r = 0; r < int'(n_row); r++) begin
        if (inst_out[2*r +: 2] != 2'b00) begin
          checks++;
          if (inst_out[2*r +: 2] !== 2'b10 || out[r*bw +: bw] !== bw'(idx[r] % 15)) begin
            failures++;
            $display("FAIL full_drain row=%0d n=%0d: got inst=%b data=%h want inst=10 data=%h",
                     r, idx[r], inst_out[2*r +: 2], out[r*bw +: bw], bw'(idx[r] % 15));
          end
          idx[r]++;
        end
      end
    end
    rd = 1'b0;
    for (int r = 0; r < int'(n_row); r++) begin
      checks++;
      if (idx[r] != int'(depth)) begin
        failures++;
        $display("FAIL full_drain_total row=%0d: got %0d want %0d", r, idx[r], depth);
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 7'd0) begin
      failures++;
      $display("FAIL full_drain_end: empty=%b full=%b count=%0d, want 1 0 0", empty, full, count);
    end
  endtask

  task automatic test_rd_empty;
    for (int c = 0; c < 5; c++) begin
      rd = 1'b1; inst_in = 2'b10; tick;
      checks++;
      if (inst_out !== '0 || empty !== 1'b1 || count !== 7'd0) begin
        failures++;
        $display("FAIL rd_empty c=%0d: inst=%h empty=%b count=%0d, want 0 1 0", c, inst_out, empty, count);
      end
    end
    rd = 1'b0; wr = 1'b1; in = mk_vec(5, 0, 16); tick;
    wr = 1'b0; rd = 1'b1; inst_in = 2'b01; tick;
    rd = 1'b0; tick;
    checks++;
    if (inst_out[1:0] !== 2'b01 || out[bw-1:0] !== 4'h5 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rd_empty_after: inst0=%b data0=%h empty=%b, want 01 5 1", inst_out[1:0], out[bw-1:0], empty);
    end
  endtask

  task automatic test_stream;
    do_reset;
    clear_idx;
    for (int c = 0; c < 201 + int'(n_row) + 2; c++) begin
      wr = (c < 200); in = mk_vec(c, 1, 16);
      rd = (c >= 1 && c <= 200); inst_in = 2'b10;
      tick;
      if (c < 200) begin
        checks++;
        if (count !== 7'd1) begin
          failures++;
          $display("FAIL stream_count c=%0d: got %0d want 1", c, count);
        end
      end
      for (int r = 0; r < int'(n_row); r++) begin
        if (inst_out[2*r +: 2] != 2'b00) begin
          checks++;
          if (inst_out[2*r +: 2] !== 2'b10 || out[r*bw +: bw] !== bw'((idx[r] + r) % 16)) begin
            failures++;
            $display("FAIL stream_data row=%0d n=%0d: got inst=%b data=%h want inst=10 data=%h",
                     r, idx[r], inst_out[2*r +: 2], out[r*bw +: bw], bw'((idx[r] + r) % 16));
          end
          idx[r]++;
        end
      end
    end
    wr = 1'b0; rd = 1'b0;
    for (int r = 0; r < int'(n_row); r++) begin
      checks++;
      if (idx[r] != 200) begin
        failures++;
        $display("FAIL stream_total row=%0d: got %0d want 200", r, idx[r]);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 7'd0) begin
      failures++;
      $display("FAIL stream_end: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_full_wr_rd;
    do_reset;
    for (int i = 0; i < int'(depth); i++) begin
      wr = 1'b1; in = mk_vec(i, 0, 15); tick;
    end
    clear_idx;
    for (int c = 0; c < int'(depth + n_row) + 2; c++) begin
      wr = (c == 0); in = mk_vec(15, 0, 16);
      rd = (c < int'(depth)); inst_in = (c == 0) ? 2'b01 : 2'b10;
      tick;
      if (c == 0) begin
        checks++;
        if (count !== 7'd63 || full !== 1'b1) begin
          failures++;
          $display("FAIL fullwr_count: count=%0d full=%b, want 63 1", count, full);
        end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (full !== (c == 7)) begin
          failures++;
          $display("FAIL fullwr_full c=%0d: got %b want %b", c, full, (c == 7));
        end
      end
      for (int r = 0; r < int'(n_row); r++) begin
        if (inst_out[2*r +: 2] != 2'b00) begin
          logic [1:0] ei;
          ei = (idx[r] == 0) ? 2'b01 : 2'b10;
          checks++;
          if (inst_out[2*r +: 2] !== ei || out[r*bw +: bw] !== bw'(idx[r] % 15)) begin
            failures++;
            $display("FAIL fullwr_data row=%0d n=%0d: got inst=%b data=%h want inst=%b data=%h",
                     r, idx[r], inst_out[2*r +: 2], out[r*bw +: bw], ei, bw'(idx[r] % 15));
          end
          idx[r]++;
        end
      end
    end
    wr = 1'b0; rd = 1'b0;
    for (int r = 0; r < int'(n_row); r++) begin
      checks++;
      if (idx[r] != int'(depth)) begin
        failures++;
        $display("FAIL fullwr_total row=%0d: got %0d want %0d", r, idx[r], depth);
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 7'd0) begin
      failures++;
      $display("FAIL fullwr_end: empty=%b full=%b count=%0d, want 1 0 0", empty, full, count);
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; in = mk_vec(i, 1, 16); tick;
    end
    wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rd = 1'b1; inst_in = 2'b10; tick;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (inst_out !== '0 || out !== '0 || empty !== 1'b1 || count !== 7'd0 || full !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: inst=%h out=%h empty=%b count=%0d full=%b, want 0 0 1 0 0",
               inst_out, out, empty, count, full);
    end
    tick;
    reset = 1'b0; rd = 1'b0;
    for (int c = 0; c < int'(n_row) + 2; c++) begin
      tick;
      checks++;
      if (inst_out !== '0 || empty !== 1'b1 || count !== 7'd0) begin
        failures++;
        $display("FAIL midreset_after c=%0d: inst=%h empty=%b count=%0d, want 0 1 0", c, inst_out, empty, count);
      end
    end
  endtask

  task automatic test_inst_values;
    wr = 1'b1; in = mk_vec(3, 0, 16); tick;
    in = mk_vec(9, 0, 16); tick;
    wr = 1'b0; rd = 1'b1; inst_in = 2'b00; tick;
    inst_in = 2'b11; tick;
    checks++;
    if (inst_out[1:0] !== 2'b00 || out[bw-1:0] !== 4'h3) begin
      failures++;
      $display("FAIL inst_flush: inst0=%b data0=%h, want 00 3", inst_out[1:0], out[bw-1:0]);
    end
    rd = 1'b0; tick;
    checks++;
    if (inst_out[1:0] !== 2'b11 || out[bw-1:0] !== 4'h9 || inst_out[3:2] !== 2'b00 || out[2*bw-1:bw] !== 4'h3) begin
      failures++;
      $display("FAIL inst_fwd11: inst0=%b data0=%h inst1=%b data1=%h, want 11 9 00 3",
               inst_out[1:0], out[bw-1:0], inst_out[3:2], out[2*bw-1:bw]);
    end
    checks++;
    if (empty !== 1'b1 || count !== 7'd0) begin
      failures++;
      $display("FAIL inst_end: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; inst_in = 2'b00; in = '0;
    test_reset;
    test_skew;
    test_full;
    test_rd_empty;
    test_stream;
    test_full_wr_rd;
    test_reset_mid_drain;
    test_inst_values;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
